hht_dot_update: RTL and testbench

Downstream consumer of the HHT control/fetch stage. It receives streamed pairs of Householder-vector element v_i and matrix-column element a_i, and accumulates the dot product v·a while buffering the pairs. It then emits the updated column a_i - w*v_i, where w = (v·a) >>> SHIFT. It processes one column per pass and feeds the write-back path.

---
 rtl/hht_dot_update_if.sv | 35 +++
 rtl/hht_dot_update.sv | 134 +++++++++++++
 tb/tb_hht_dot_update.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hht_dot_update_if.sv
// ============================================================================
// hht_dot_update_if : pair-in / result-out stream bundle for hht_dot_update
// Rev 1.0
// ============================================================================
`default_nettype none

interface hht_dot_update_if #(
  parameter int DW = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   v_in;
  logic signed [DW-1:0]   a_in;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [DW-1:0]   res_out;
  logic                   out_last;
  logic signed [2*DW-1:0] dot_out;
  logic                   busy;
  logic                   done;
  logic                   len_err;

  modport slave (
    input  in_valid, v_in, a_in, in_last, out_ready,
    output in_ready, out_valid, res_out, out_last, dot_out, busy, done, len_err
  );

  modport master (
    output in_valid, v_in, a_in, in_last, out_ready,
    input  in_ready, out_valid, res_out, out_last, dot_out, busy, done, len_err
  );
endinterface

`default_nettype wire

// File: rtl/hht_dot_update.sv
// ============================================================================
// hht_dot_update : buffers (v,a) pairs, accumulates v.a, emits a - ((v.a)>>>SHIFT)*v
// Rev 1.0
// ============================================================================
`default_nettype none

module hht_dot_update #(
  parameter int VLEN  = 32,
  parameter int DW    = 32,
  parameter int SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst,
  hht_dot_update_if.slave    bus
);

  localparam int AW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int CW = $clog2(VLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_SCALE = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic signed [2*DW-1:0] r_acc;
  logic signed [2*DW-1:0] r_dot;
  logic [DW-1:0]          r_w;
  logic [CW-1:0]          r_count;
  logic [AW-1:0]          r_rd_ptr;
  logic                   r_len_err;
  logic                   r_done;
  logic [DW-1:0]          r_buf_v [VLEN];
  logic [DW-1:0]          r_buf_a [VLEN];

  logic                   w_in_ready;
  logic                   w_in_fire;
  logic [CW-1:0]          w_wr_idx;
  logic                   w_full;
  logic                   w_col_end;
  logic [2*DW-1:0]        w_v_ext;
  logic [2*DW-1:0]        w_a_ext;
  logic [2*DW-1:0]        w_prod;
  logic [2*DW-1:0]        w_acc_base;
  logic                   w_emit;
  logic                   w_last_out;
  logic                   w_out_fire;
  logic [DW-1:0]          w_rd_v;
  logic [DW-1:0]          w_rd_a;
  logic [DW-1:0]          w_wv;
  logic [DW-1:0]          w_res;

  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_ACC);
  assign w_in_fire  = bus.in_valid && w_in_ready;

  // The first pair of a column always lands at slot 0, whatever count was left over.
  assign w_wr_idx   = (r_state == S_IDLE) ? '0 : r_count;
  assign w_full     = (w_wr_idx == CW'(VLEN - 1));
  assign w_col_end  = w_in_fire && (bus.in_last || w_full);

  // Operands are sign-extended to 2*DW so the low 2*DW product bits are the signed product.
  assign w_v_ext    = {{DW{bus.v_in[DW-1]}}, bus.v_in};
  assign w_a_ext    = {{DW{bus.a_in[DW-1]}}, bus.a_in};
  assign w_prod     = w_v_ext * w_a_ext;
  assign w_acc_base = (r_state == S_IDLE) ? '0 : r_acc;

  assign w_emit     = (r_state == S_EMIT);
  assign w_last_out = w_emit && (CW'(r_rd_ptr) == (r_count - CW'(1)));
  assign w_out_fire = w_emit && bus.out_ready;
  assign w_rd_v     = r_buf_v[r_rd_ptr];
  assign w_rd_a     = r_buf_a[r_rd_ptr];
  assign w_wv       = r_w * w_rd_v;
  assign w_res      = w_rd_a - w_wv;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_fire) w_next = w_col_end ? S_SCALE : S_ACC;
      S_ACC:   if (w_col_end) w_next = S_SCALE;
      S_SCALE: w_next = S_EMIT;
      S_EMIT:  if (w_out_fire && w_last_out) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_dot     <= '0;
      r_w       <= '0;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_len_err <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_out_fire && w_last_out;
      if (w_in_fire) begin
        r_acc   <= w_acc_base + w_prod;
        r_count <= w_wr_idx + CW'(1);
        if (w_full && !bus.in_last) r_len_err <= 1'b1;
      end
      if (r_state == S_SCALE) begin
        r_dot    <= r_acc;
        r_w      <= DW'(r_acc >>> SHIFT);
        r_rd_ptr <= '0;
      end
      if (w_out_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf_v[w_wr_idx[AW-1:0]] <= bus.v_in;
      r_buf_a[w_wr_idx[AW-1:0]] <= bus.a_in;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_emit;
  assign bus.res_out   = w_emit ? w_res : '0;
  assign bus.out_last  = w_last_out;
  assign bus.dot_out   = r_dot;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.len_err   = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_hht_dot_update.sv
// ============================================================================
// tb_hht_dot_update : directed bench with a column-level model and stream checker
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hht_dot_update;

  localparam int DW   = 32;
  localparam int VLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hht_dot_update_if #(.DW(DW)) bus ();
  hht_dot_update_if #(.DW(DW)) bus2 ();

  hht_dot_update #(.VLEN(VLEN), .DW(DW), .SHIFT(0)) dut  (.clk(clk), .rst(rst), .bus(bus));
  hht_dot_update #(.VLEN(VLEN), .DW(DW), .SHIFT(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad   = 0;

  int cv [64];
  int ca [64];
  int exp_res [512];
  bit exp_last [512];
  int wp = 0;
  int rd = 0;
  int got_log [512];
  int gcnt = 0;
  int got2 [4];
  bit bp_mode = 1'b0;
  bit bp_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string name, input longint got, input longint expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Column model: dot product of the whole column, then a_i - w*v_i in DW-bit wrap.
  function automatic longint model_dot(input int n);
    longint d = 0;
    for (int i = 0; i < n; i++) d += longint'(cv[i]) * longint'(ca[i]);
    return d;
  endfunction

  function automatic int model_res(input int n, input int sh, input int i);
    int w;
    w = int'(model_dot(n) >>> sh);
    return ca[i] - w * cv[i];
  endfunction

  initial begin
    bus.out_ready  = 1'b1;
    bus2.out_ready = 1'b1;
    forever begin
      int idx = 0;
      while (1) begin
        @(posedge clk);
        #1;
        if (bp_mode) begin
          bus.out_ready = bp_pat[idx % 5];
          idx++;
        end else begin
          bus.out_ready = 1'b1;
          idx = 0;
        end
      end
    end
  end

  bit exp_done_q = 1'b0;
  bit stall_q    = 1'b0;
  int stall_res  = 0;
  bit stall_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rd         = wp;
      exp_done_q = 1'b0;
      stall_q    = 1'b0;
    end else begin
      if (exp_done_q) begin
        chk("done_pulse", bus.done, 1);
        exp_done_q = 1'b0;
      end else if (bus.done) begin
        chk("done_spurious", bus.done, 0);
      end
      if (stall_q) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_res", bus.res_out, stall_res);
        chk("hold_last", bus.out_last, stall_last);
      end
      if (bus.out_valid) begin
        if (rd == wp) begin
          chk("unexpected_out", bus.out_valid, 0);
        end else if (bus.out_ready) begin
          chk("res_out", bus.res_out, exp_res[rd]);
          chk("out_last", bus.out_last, exp_last[rd]);
          got_log[gcnt] = bus.res_out;
          gcnt++;
          if (exp_last[rd]) exp_done_q = 1'b1;
          rd++;
        end
      end
      stall_q    = bus.out_valid && !bus.out_ready;
      stall_res  = bus.res_out;
      stall_last = bus.out_last;
    end
  end

  task automatic send_pair(input int v, input int a, input bit last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.v_in     = v;
    bus.a_in     = a;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("in_accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_col(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      exp_res[wp]  = model_res(n, 0, i);
      exp_last[wp] = (i == n - 1);
      wp++;
    end
    for (int i = 0; i < n; i++) send_pair(cv[i], ca[i], with_last && (i == n - 1));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus.busy || rd != wp) && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("idle_timeout", (t < 300), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input int v, input int a, input bit last);
    int t = 0;
    bus2.in_valid = 1'b1;
    bus2.v_in     = v;
    bus2.a_in     = a;
    bus2.in_last  = last;
    @(negedge clk);
    while (!bus2.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus2.in_ready) chk("s1_accept_timeout", bus2.in_ready, 1);
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    bus2.in_last  = 1'b0;
  endtask

  task automatic run2(input int n);
    int t = 0;
    for (int i = 0; i < n; i++) send2(cv[i], ca[i], i == n - 1);
    @(negedge clk);
    while (!bus2.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("s1_valid", bus2.out_valid, 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk("s1_res", bus2.res_out, model_res(n, 1, i));
      chk("s1_last", bus2.out_last, (i == n - 1));
      got2[i] = bus2.res_out;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("s1_dot_model", bus2.dot_out, model_dot(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g0;
    bus.in_valid  = 1'b0; bus.v_in  = '0; bus.a_in  = '0; bus.in_last  = 1'b0;
    bus2.in_valid = 1'b0; bus2.v_in = '0; bus2.a_in = '0; bus2.in_last = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_res_out", bus.res_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_len_err", bus.len_err, 0);
    chk("rst_dot_out", bus.dot_out, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three-element column, full throughput
    cv[0] = 1; cv[1] = 2; cv[2] = 3;
    ca[0] = 4; ca[1] = 5; ca[2] = 6;
    g0 = gcnt;
    send_col(3, 1'b1);
    chk("lat_scale_valid", bus.out_valid, 0);
    chk("lat_scale_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    chk("lat_emit_valid", bus.out_valid, 1);
    wait_idle();
    chk("t1_dot", bus.dot_out, 32);
    chk("t1_r0", got_log[g0], -28);
    chk("t1_r1", got_log[g0+1], -59);
    chk("t1_r2", got_log[g0+2], -90);
    chk("t1_busy", bus.busy, 0);

    // Single-element column
    cv[0] = 1; ca[0] = 7;
    g0 = gcnt;
    send_col(1, 1'b1);
    wait_idle();
    chk("t2_dot", bus.dot_out, 7);
    chk("t2_r0", got_log[g0], 0);
    chk("t2_busy", bus.busy, 0);

    // Backpressure on the result stream
    cv[0] = 1; cv[1] = 2; cv[2] = 3;
    ca[0] = 4; ca[1] = 5; ca[2] = 6;
    g0 = gcnt;
    bp_mode = 1'b1;
    send_col(3, 1'b1);
    wait_idle();
    bp_mode = 1'b0;
    chk("t3_count", gcnt - g0, 3);
    chk("t3_r0", got_log[g0], -28);
    chk("t3_r1", got_log[g0+1], -59);
    chk("t3_r2", got_log[g0+2], -90);

    // SHIFT=1 instance: positive and negative dot products
    cv[0] = 1; cv[1] = 1; ca[0] = 3; ca[1] = 4;
    run2(2);
    chk("s1_dot_pos", bus2.dot_out, 7);
    chk("s1_pos_r0", got2[0], 0);
    chk("s1_pos_r1", got2[1], 1);
    ca[0] = -3; ca[1] = -4;
    run2(2);
    chk("s1_dot_neg", bus2.dot_out, -7);
    chk("s1_neg_r0", got2[0], 1);
    chk("s1_neg_r1", got2[1], 0);

    // Overrun: VLEN pairs with no in_last, then one more pair
    for (int i = 0; i < VLEN; i++) begin
      cv[i] = 1;
      ca[i] = i;
    end
    g0 = gcnt;
    send_col(VLEN, 1'b0);
    chk("ovr_in_ready", bus.in_ready, 0);
    chk("ovr_len_err", bus.len_err, 1);
    cv[0] = 1; ca[0] = 100;
    send_col(1, 1'b1);
    chk("ovr_drained_first", gcnt - g0, VLEN);
    chk("ovr_dot", bus.dot_out, 496);
    chk("ovr_r0", got_log[g0], -496);
    chk("ovr_r31", got_log[g0+31], -465);
    wait_idle();
    chk("ovr_next_dot", bus.dot_out, 100);
    chk("ovr_len_err_sticky", bus.len_err, 1);

    // Reset in the middle of EMIT
    begin
      int t = 0;
      cv[0] = 1; cv[1] = 2; cv[2] = 3;
      ca[0] = 4; ca[1] = 5; ca[2] = 6;
      send_col(3, 1'b1);
      while (rd != wp - 2 && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("mid_emit_reached", (rd == wp - 2), 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_len_err", bus.len_err, 0);
    chk("mid_rst_dot", bus.dot_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_done", bus.done, 0);
    cv[0] = 2; ca[0] = 5;
    g0 = gcnt;
    send_col(1, 1'b1);
    wait_idle();
    chk("post_rst_dot", bus.dot_out, 10);
    chk("post_rst_r0", got_log[g0], -15);
    chk("post_rst_len_err", bus.len_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
